// File: rtl/bnn_sequencer.sv
// bnn_sequencer: top-level phase controller for the MNIST BNN accelerator.
// It sequences CLEAR -> LOAD -> LAYER_1 -> LAYER_2 -> LAYER_3 -> DONE and
// drives the shared 3-bit phase code seen by the loader and layer datapaths.
// It also captures the final class index from layer 3.
//
// Optional feature: define BNN_SEQ_WATCHDOG_EN to build the per-phase
// watchdog. When the watchdog is present, a stalled phase forces the ERROR
// state. Without it, the phase counter is not built, ERROR cannot be reached,
// and error/err_phase are tied low.
//
// Handshake semantics:
//   start        level request, honoured in IDLE and DONE only
//   layer_start  one-cycle request pulse, issued in the first cycle of LAYER_k
//   load_done    level completion flag, honoured only in LOAD
//   layer_done   level completion flag; bit k is honoured only in LAYER_k+1,
//                other bits are ignored
//   class_in     qualified by layer_done[2] while in LAYER_3
//   abort        overrides every other input and returns to IDLE
//
// All outputs come from registers or from decoding the registered state.
// There is therefore no combinational path from any input to any output.
module bnn_sequencer #(
    parameter int LOAD_TIMEOUT  = 4096,
    parameter int LAYER_TIMEOUT = 1024,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       load_done,
    input  logic [2:0] layer_done,
    input  logic [3:0] class_in,
    output logic [2:0] state,
    output logic       regs_clr_n,
    output logic [2:0] layer_start,
    output logic       busy,
    output logic [3:0] result,
    output logic       result_valid,
    output logic       error,
    output logic [2:0] err_phase,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_L1    = 3'd3,
        S_L2    = 3'd4,
        S_L3    = 3'd5,
        S_DONE  = 3'd6,
        S_ERROR = 3'd7
    } fsm_t;

    // Phase codes shared with the loader and the layer datapaths
    localparam logic [2:0] PH_IDLE = 3'b000;
    localparam logic [2:0] PH_LOAD = 3'b001;
    localparam logic [2:0] PH_L1   = 3'b010;
    localparam logic [2:0] PH_L2   = 3'b011;
    localparam logic [2:0] PH_L3   = 3'b100;

    fsm_t       cur_q;
    fsm_t       nxt;
    logic [2:0] layer_start_q;
    logic [2:0] layer_start_nxt;
    logic [3:0] result_q;
    logic       capture;
    logic       timeout;
    logic [2:0] phase_code;
    logic       in_phase;

    // Decode the shared phase code from the registered FSM state
    always_comb begin
        phase_code = PH_IDLE;
        case (cur_q)
            S_LOAD:  phase_code = PH_LOAD;
            S_L1:    phase_code = PH_L1;
            S_L2:    phase_code = PH_L2;
            S_L3:    phase_code = PH_L3;
            default: phase_code = PH_IDLE;
        endcase
    end

    // The timed phases are exactly those that have a nonzero phase code
    assign in_phase = (phase_code != PH_IDLE);

    // Next-state logic. Abort is checked first so it beats start, the done
    // inputs and the timeout. Inside a phase, the matching done is checked
    // before the timeout, so done wins when both occur in the same cycle.
    always_comb begin
        nxt             = cur_q;
        layer_start_nxt = 3'b000;
        capture         = 1'b0;
        if (abort) begin
            nxt = S_IDLE;
        end else begin
            case (cur_q)
                S_IDLE, S_DONE: begin
                    if (start) nxt = S_CLEAR;
                end
                S_CLEAR: begin
                    nxt = S_LOAD;
                end
                S_LOAD: begin
                    if (load_done) begin
                        nxt             = S_L1;
                        layer_start_nxt = 3'b001;
                    end else if (timeout) begin
                        nxt = S_ERROR;
                    end
                end
                S_L1: begin
                    if (layer_done[0]) begin
                        nxt             = S_L2;
                        layer_start_nxt = 3'b010;
                    end else if (timeout) begin
                        nxt = S_ERROR;
                    end
                end
                S_L2: begin
                    if (layer_done[1]) begin
                        nxt             = S_L3;
                        layer_start_nxt = 3'b100;
                    end else if (timeout) begin
                        nxt = S_ERROR;
                    end
                end
                S_L3: begin
                    if (layer_done[2]) begin
                        nxt     = S_DONE;
                        capture = 1'b1;
                    end else if (timeout) begin
                        nxt = S_ERROR;
                    end
                end
                S_ERROR: begin
                    nxt = S_ERROR;
                end
                default: begin
                    nxt = S_IDLE;
                end
            endcase
        end
    end

    // State register, registered layer_start pulse, and class-index capture.
    // The result is only reloaded on the L3 completion edge, so abort and
    // re-start leave it unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_q         <= S_IDLE;
            layer_start_q <= 3'b000;
            result_q      <= 4'd0;
        end else begin
            cur_q         <= nxt;
            layer_start_q <= layer_start_nxt;
            if (capture) begin
                result_q <= class_in;
            end
        end
    end

`ifdef BNN_SEQ_WATCHDOG_EN
    // Each phase may occupy at most its TIMEOUT cycles. The counter shows
    // the number of cycles already spent in the phase. The timeout fires on
    // the edge that would take the count to TIMEOUT.
    localparam logic [CNT_W-1:0] LOAD_LIM  = CNT_W'(LOAD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LAYER_LIM = CNT_W'(LAYER_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       err_phase_q;

    // Compare the phase counter against the limit for the current phase
    always_comb begin
        timeout = 1'b0;
        case (cur_q)
            S_LOAD:           timeout = (cnt_q == LOAD_LIM);
            S_L1, S_L2, S_L3: timeout = (cnt_q == LAYER_LIM);
            default:          timeout = 1'b0;
        endcase
    end

    // Phase counter: reset on every state change, saturating count in phases
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (nxt != cur_q) begin
            cnt_q <= '0;
        end else if (in_phase && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Record the phase that stalled; the record survives abort until a CLEAR
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_phase_q <= 3'b000;
        end else if ((nxt == S_ERROR) && (cur_q != S_ERROR)) begin
            err_phase_q <= phase_code;
        end else if ((nxt == S_CLEAR) && (cur_q != S_CLEAR)) begin
            err_phase_q <= 3'b000;
        end
    end

    assign error     = (cur_q == S_ERROR);
    assign err_phase = err_phase_q;
`else
    // With no watchdog, the timeout never fires and ERROR is unreachable.
    // The timeout parameters are carried only so that both builds keep the
    // same parameter list.
    logic unused_cfg;

    assign timeout    = 1'b0;
    assign error      = 1'b0;
    assign err_phase  = 3'b000;
    assign unused_cfg = ^{LOAD_TIMEOUT[0], LAYER_TIMEOUT[0], CNT_W[0]};
`endif

    assign state        = phase_code;
    assign regs_clr_n   = (cur_q != S_CLEAR);
    assign layer_start  = layer_start_q;
    assign busy         = (cur_q != S_IDLE) && (cur_q != S_DONE) && (cur_q != S_ERROR);
    assign result       = result_q;
    assign result_valid = (cur_q == S_DONE);
    assign fsm_state    = cur_q;

endmodule

// File: doc/bnn_sequencer.md
# bnn_sequencer

Top-level phase controller for the MNIST BNN accelerator. It accepts a start request, clears and enables the serial image/weight loader, then runs layers 1–3 in order using start/done handshakes. It drives the shared 3-bit phase code seen by the loader and layer datapaths, and captures the final class index. An optional per-phase watchdog forces an error state if any phase stalls.

## Interface
- `LOAD_TIMEOUT`, default 4096: maximum cycles allowed in LOAD.
- `LAYER_TIMEOUT`, default 1024: maximum cycles allowed in each LAYER_x phase.
- `CNT_W`, default 16: phase-counter width. Must satisfy 2^CNT_W > max(timeouts).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  inference request; level-sampled.
- `abort`  in  1  return to IDLE from any state.
- `load_done`  in  1  loader reports image and all weights captured.
- `layer_done`  in  3  bit k = layer k+1 finished; each bit sampled only in its own phase.
- `class_in`  in  4  layer-3 argmax output; valid with `layer_done[2]`.
- `state`  out  3  phase code: 000 IDLE, 001 LOAD, 010 LAYER_1, 011 LAYER_2, 100 LAYER_3.
- `regs_clr_n`  out  1  active-low synchronous clear to the loader.
- `layer_start`  out  3  one-cycle pulse on entry to LAYER_k.
- `busy`  out  1  high in any state except IDLE, DONE and ERROR.
- `result`  out  4  captured class index.
- `result_valid`  out  1  high while in DONE.
- `error`  out  1  high while in ERROR.
- `err_phase`  out  3  phase code that timed out.

## Operation
- Internal FSM states: IDLE, CLEAR, LOAD, L1, L2, L3, DONE, ERROR.
- `state` output per FSM state: IDLE/CLEAR/DONE/ERROR drive 000; LOAD 001; L1 010; L2 011; L3 100.
- IDLE or DONE with `start`=1 -> CLEAR. Entering CLEAR drops `result_valid`.
- CLEAR lasts exactly one cycle with `regs_clr_n`=0, then goes to LOAD. `regs_clr_n`=1 in every other state.
- LOAD with `load_done`=1 -> L1 and pulses `layer_start[0]`.
- L1 with `layer_done[0]` -> L2 and pulses `layer_start[1]`.
- L2 with `layer_done[1]` -> L3 and pulses `layer_start[2]`.
- L3 with `layer_done[2]` -> DONE; `result` <= `class_in` on the same edge.
- `layer_done` bits not matching the current phase are ignored.
- DONE holds `result` and `result_valid`=1 until `start` or `abort`.
- `abort`=1 in any state -> IDLE on the next edge. `abort` has priority over `start`, done inputs and timeout. `result` keeps its value; `result_valid` clears.
- ERROR is left only by `abort` or `reset`. `start` is ignored in ERROR.
- Phase counter: cleared on every state transition; increments each cycle in LOAD, L1, L2 and L3; saturates at its maximum value.

## Timing
- Reset values: FSM=IDLE, `state`=000, `regs_clr_n`=1, `layer_start`=000, `busy`=0, `result`=0, `result_valid`=0, `error`=0, `err_phase`=000, counter=0.
- All outputs are registered or decoded from registered state; there is no combinational input-to-output path.
- Start cycle N (in IDLE) -> CLEAR at N+1 -> `state`=001 at N+2. The first pixel/weight bit is captured at the N+2 edge.
- A done input at cycle M -> next phase code and `layer_start` pulse visible at M+1.
- A done input and the timeout condition in the same cycle: done wins.
- Reset asserted mid-phase: immediate return to reset values. The loader contents are not cleared until the next CLEAR.

## Configuration
- `BNN_SEQ_WATCHDOG_EN` defined:
  - Timeout fires when the counter reaches LOAD_TIMEOUT (in LOAD) or LAYER_TIMEOUT (in L1–L3) without the matching done.
  - On timeout -> ERROR, with `err_phase` = the phase code of the stalled phase.
  - `err_phase` holds until the next CLEAR or `reset`.
- `BNN_SEQ_WATCHDOG_EN` undefined:
  - Counter and timeout logic are not built.
  - ERROR is unreachable; `error` and `err_phase` are tied to 0.

## Test plan
- Normal run: reset, `start` pulse, `load_done` after 2320 cycles, each layer done after 50 cycles, `class_in`=7. Expect `state` sequence 000,000,001,010,011,100,000; one `layer_start` pulse per layer; `result`=7; `result_valid`=1; `busy` low in DONE.
- Clear pulse: `start` at cycle 10. Expect `regs_clr_n`=0 only at cycle 11 and `state`=001 at cycle 12.
- Out-of-phase done: `layer_done`=3'b110 during LOAD and L1. Expect no transition until the matching bit asserts.
- Abort: `abort` together with `start` in IDLE, then abort during L2. Expect to stay in / return to IDLE next cycle, `busy`=0, `result_valid`=0, previous `result` retained.
- Watchdog (macro defined, `LAYER_TIMEOUT`=8): stall in L2. Expect `error`=1 and `err_phase`=011 at the 8th L2 cycle; `start` ignored; `abort` returns to IDLE.
- Back-to-back runs: `start` while in DONE. Expect CLEAR, then a full second run; `result` updates to the new `class_in`.
